// File: rtl/phshift_gain_ramp_pkg.sv
// Shared constants for the phase-shifter gain-pair ramp controller:
// local-bus register map, controller state encoding and datapath widths.
package phshift_gain_ramp_pkg;

   localparam int GAIN_W = 16;   // live/target gain width (signed)
   localparam int DIFF_W = 17;   // target - gain never overflows at this width
   localparam int STEP_W = 15;   // slew step magnitude (unsigned)

   localparam logic [1:0] ADDR_SHADOW1 = 2'd0;
   localparam logic [1:0] ADDR_SHADOW2 = 2'd1;
   localparam logic [1:0] ADDR_STEP    = 2'd2;
   localparam logic [1:0] ADDR_RATE    = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_e;

endpackage

// File: rtl/phshift_gain_ramp_step.sv
// Combinational slew limiter: moves cur toward tgt by at most step.
// step==0 means "jump straight to the target". All arithmetic is done at
// 17 bits so the result neither overshoots the target nor wraps.
module phshift_gain_ramp_step
   import phshift_gain_ramp_pkg::*;
(
   input  logic signed [GAIN_W-1:0] cur_i,
   input  logic signed [GAIN_W-1:0] tgt_i,
   input  logic        [STEP_W-1:0] step_i,
   output logic signed [GAIN_W-1:0] nxt_o
);

   logic signed [DIFF_W-1:0] cur_x, tgt_x, diff, step_x, sum;
   logic        [DIFF_W-1:0] mag;

   // Limit the per-tick move to step, landing exactly on the target when close
   always_comb begin
      cur_x  = {cur_i[GAIN_W-1], cur_i};
      tgt_x  = {tgt_i[GAIN_W-1], tgt_i};
      step_x = {2'b00, step_i};
      diff   = tgt_x - cur_x;
      mag    = diff[DIFF_W-1] ? $unsigned(-diff) : $unsigned(diff);
      sum    = '0;
      nxt_o  = tgt_i;
      if (step_i != '0 && mag > $unsigned(step_x)) begin
         sum   = diff[DIFF_W-1] ? (cur_x - step_x) : (cur_x + step_x);
         nxt_o = sum[GAIN_W-1:0];
      end
   end

endmodule

// File: rtl/phshift_gain_ramp.sv
// Gain-pair ramp controller for the fs/8 phase shifter. Shadow gains are
// written over the local bus and committed atomically; the live gains then
// slew toward the targets at a programmable step and rate.
// Build option: define PHSHIFT_GAIN_RAMP_SNAP_EN to drop the ramp engine and
// load the live gains directly on commit.
module phshift_gain_ramp
   import phshift_gain_ramp_pkg::*;
#(
   parameter int                       RATE_W     = 8,
   parameter logic signed [GAIN_W-1:0] GAIN1_INIT = 16'sd0,
   parameter logic signed [GAIN_W-1:0] GAIN2_INIT = 16'sd0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [1:0]               lb_addr_i,
   input  logic [15:0]              lb_data_i,
   input  logic                     lb_write_i,
   input  logic                     commit_i,
   output logic signed [GAIN_W-1:0] gain1_o,
   output logic signed [GAIN_W-1:0] gain2_o,
   output logic                     busy_o,
   output logic                     done_o
);

   logic signed [GAIN_W-1:0] shadow1_q, shadow1_d, shadow2_q, shadow2_d;
   logic signed [GAIN_W-1:0] gain1_q, gain1_d, gain2_q, gain2_d;
   logic                     done_q, done_d;

   // Shadow registers: a bus write lands next cycle, never touches live gains
   always_comb begin
      shadow1_d = shadow1_q;
      shadow2_d = shadow2_q;
      if (lb_write_i && lb_addr_i == ADDR_SHADOW1) shadow1_d = lb_data_i;
      if (lb_write_i && lb_addr_i == ADDR_SHADOW2) shadow2_d = lb_data_i;
   end

`ifdef PHSHIFT_GAIN_RAMP_SNAP_EN

   // Snap mode: commit copies shadows straight to the live gains
   always_comb begin
      gain1_d = gain1_q;
      gain2_d = gain2_q;
      done_d  = 1'b0;
      if (commit_i) begin
         gain1_d = shadow1_q;
         gain2_d = shadow2_q;
         done_d  = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow1_q <= GAIN1_INIT;
         shadow2_q <= GAIN2_INIT;
         gain1_q   <= GAIN1_INIT;
         gain2_q   <= GAIN2_INIT;
         done_q    <= 1'b0;
      end else begin
         shadow1_q <= shadow1_d;
         shadow2_q <= shadow2_d;
         gain1_q   <= gain1_d;
         gain2_q   <= gain2_d;
         done_q    <= done_d;
      end
   end

   assign busy_o = 1'b0;

`else

   state_e                   state_q, state_d;
   logic signed [GAIN_W-1:0] target1_q, target1_d, target2_q, target2_d;
   logic        [STEP_W-1:0] step_q, step_d;
   logic        [RATE_W-1:0] rate_q, rate_d, presc_q, presc_d;
   logic signed [GAIN_W-1:0] nxt1, nxt2;
   logic                     tick;

   phshift_gain_ramp_step u_step1 (
      .cur_i (gain1_q), .tgt_i (target1_q), .step_i (step_q), .nxt_o (nxt1)
   );
   phshift_gain_ramp_step u_step2 (
      .cur_i (gain2_q), .tgt_i (target2_q), .step_i (step_q), .nxt_o (nxt2)
   );

   // >= rather than == so a rate lowered mid-count still ticks promptly
   assign tick = (state_q == ST_RAMP) && (presc_q >= rate_q);

   // Ramp FSM, prescaler and gain update. A commit wins over a coincident
   // tick: it retargets and restarts the prescaler without moving the gains.
   always_comb begin
      state_d   = state_q;
      target1_d = target1_q;
      target2_d = target2_q;
      gain1_d   = gain1_q;
      gain2_d   = gain2_q;
      presc_d   = presc_q;
      step_d    = step_q;
      rate_d    = rate_q;
      done_d    = 1'b0;
      if (lb_write_i && lb_addr_i == ADDR_STEP) step_d = lb_data_i[STEP_W-1:0];
      if (lb_write_i && lb_addr_i == ADDR_RATE) rate_d = lb_data_i[RATE_W-1:0];
      if (commit_i) begin
         target1_d = shadow1_q;
         target2_d = shadow2_q;
         presc_d   = '0;
         state_d   = ST_RAMP;
      end else if (state_q == ST_RAMP) begin
         presc_d = tick ? '0 : presc_q + RATE_W'(1);
         if (tick) begin
            gain1_d = nxt1;
            gain2_d = nxt2;
            if (nxt1 == target1_q && nxt2 == target2_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               presc_d = '0;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         shadow1_q <= GAIN1_INIT;
         shadow2_q <= GAIN2_INIT;
         target1_q <= GAIN1_INIT;
         target2_q <= GAIN2_INIT;
         gain1_q   <= GAIN1_INIT;
         gain2_q   <= GAIN2_INIT;
         step_q    <= '0;
         rate_q    <= '0;
         presc_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow1_q <= shadow1_d;
         shadow2_q <= shadow2_d;
         target1_q <= target1_d;
         target2_q <= target2_d;
         gain1_q   <= gain1_d;
         gain2_q   <= gain2_d;
         step_q    <= step_d;
         rate_q    <= rate_d;
         presc_q   <= presc_d;
         done_q    <= done_d;
      end
   end

   assign busy_o = (state_q == ST_RAMP);

`endif

   assign gain1_o = gain1_q;
   assign gain2_o = gain2_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_phshift_gain_ramp.sv
// Directed bench for phshift_gain_ramp. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_phshift_gain_ramp;
   import phshift_gain_ramp_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         lb_addr;
   logic [15:0]        lb_data;
   logic               lb_write;
   logic               commit;
   logic signed [15:0] gain1, gain2;
   logic               busy, done;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   phshift_gain_ramp dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .lb_addr_i  (lb_addr),
      .lb_data_i  (lb_data),
      .lb_write_i (lb_write),
      .commit_i   (commit),
      .gain1_o    (gain1),
      .gain2_o    (gain2),
      .busy_o     (busy),
      .done_o     (done)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      lb_addr  = a;
      lb_data  = d;
      lb_write = 1'b1;
      cyc();
      lb_write = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      cyc();
      commit = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; lb_write = 1'b0; commit = 1'b0; lb_addr = '0; lb_data = '0;
      cyc(); cyc();
      nvec++;
      if ({gain1, gain2, busy, done} !== 34'b0) begin
         nerr++;
         $display("FAIL reset: got g1=%0d g2=%0d busy=%b done=%b want 0 0 0 0",
                  gain1, gain2, busy, done);
      end
      rst = 1'b0;
      cyc();
   endtask

`ifdef PHSHIFT_GAIN_RAMP_SNAP_EN

   task automatic test_snap();
      wr(ADDR_SHADOW1, 16'd1000);
      wr(ADDR_SHADOW2, 16'hFC18);   // -1000
      wr(ADDR_STEP, 16'd100);
      wr(ADDR_RATE, 16'd5);
      nvec++;
      if ({gain1, gain2} !== 32'h0) begin
         nerr++; $display("FAIL snap_pre: got %0d/%0d want 0/0", gain1, gain2);
      end
      pulse_commit();
      nvec++;
      if ({gain1, gain2, busy, done} !== {16'd1000, 16'hFC18, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL snap_load: got %0d/%0d busy=%b done=%b want 1000/-1000 0 1",
                  gain1, gain2, busy, done);
      end
      cyc();
      nvec++;
      if (done !== 1'b0) begin
         nerr++; $display("FAIL snap_done_clr: got %b want 0", done);
      end
   endtask

`else

   // Test 1: step 100, rate 0, 0 -> 1000 / -1000 in 10 ticks
   task automatic test_ramp_basic();
      wr(ADDR_SHADOW1, 16'd1000);
      wr(ADDR_SHADOW2, 16'hFC18);
      wr(ADDR_STEP, 16'd100);
      wr(ADDR_RATE, 16'd0);
      nvec++;
      if ({gain1, gain2} !== 32'h0) begin
         nerr++; $display("FAIL t1_shadow_only: got %0d/%0d want 0/0", gain1, gain2);
      end
      pulse_commit();
      for (int k = 1; k <= 10; k++) begin
         nvec++;
         if ({gain1, gain2, busy, done} !==
             {16'(100*(k-1)), 16'(-100*(k-1)), 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL t1_ramp k=%0d: got %0d/%0d busy=%b done=%b want %0d/%0d 1 0",
                     k, gain1, gain2, busy, done, 100*(k-1), -100*(k-1));
         end
         cyc();
      end
      nvec++;
      if ({gain1, gain2, busy, done} !== {16'd1000, 16'hFC18, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL t1_end: got %0d/%0d busy=%b done=%b want 1000/-1000 0 1",
                  gain1, gain2, busy, done);
      end
      cyc();
      nvec++;
      if (done !== 1'b0) begin
         nerr++; $display("FAIL t1_done_once: got %b want 0", done);
      end
   endtask

   // Test 2: rate 3, big step toward full scale, no wrap
   task automatic test_rate_wrap();
      rst = 1'b1; cyc(); rst = 1'b0;
      wr(ADDR_STEP, 16'd16384);
      wr(ADDR_RATE, 16'd3);
      wr(ADDR_SHADOW1, 16'h7FFF);
      wr(ADDR_SHADOW2, 16'h8000);
      pulse_commit();
      for (int k = 1; k <= 8; k++) begin
         nvec++;
         if ({gain1, gain2, busy, done} !==
             ((k <= 4) ? {32'h0, 1'b1, 1'b0} : {16'h4000, 16'hC000, 1'b1, 1'b0})) begin
            nerr++;
            $display("FAIL t2_ramp k=%0d: got %0d/%0d busy=%b done=%b",
                     k, gain1, gain2, busy, done);
         end
         cyc();
      end
      nvec++;
      if ({gain1, gain2, busy, done} !== {16'h7FFF, 16'h8000, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL t2_end: got %0d/%0d busy=%b done=%b want 32767/-32768 0 1",
                  gain1, gain2, busy, done);
      end
   endtask

   // Test 3: step 0 jumps straight to the target on the first tick
   task automatic test_step_zero();
      wr(ADDR_STEP, 16'd0);
      wr(ADDR_RATE, 16'd0);
      wr(ADDR_SHADOW1, 16'hFE0C);   // -500
      pulse_commit();
      nvec++;
      if ({gain1, busy, done} !== {16'h7FFF, 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL t3_first: got %0d busy=%b done=%b want 32767 1 0", gain1, busy, done);
      end
      cyc();
      nvec++;
      if ({gain1, gain2, busy, done} !== {16'hFE0C, 16'h8000, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL t3_jump: got %0d/%0d busy=%b done=%b want -500/-32768 0 1",
                  gain1, gain2, busy, done);
      end
   endtask

   // Test 4: retarget mid-ramp at gain1=300 back to 0
   task automatic test_retarget();
      rst = 1'b1; cyc(); rst = 1'b0;
      wr(ADDR_STEP, 16'd100);
      wr(ADDR_SHADOW1, 16'd1000);
      pulse_commit();
      cyc(); cyc();
      nvec++;
      if (gain1 !== 16'sd200) begin
         nerr++; $display("FAIL t4_pre: got %0d want 200", gain1);
      end
      wr(ADDR_SHADOW1, 16'd0);
      nvec++;
      if ({gain1, busy, done} !== {16'd300, 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL t4_at300: got %0d busy=%b done=%b want 300 1 0", gain1, busy, done);
      end
      pulse_commit();
      for (int k = 0; k < 3; k++) begin
         nvec++;
         if ({gain1, busy, done} !== {16'(300 - 100*k), 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL t4_down k=%0d: got %0d busy=%b done=%b want %0d 1 0",
                     k, gain1, busy, done, 300 - 100*k);
         end
         cyc();
      end
      nvec++;
      if ({gain1, gain2, busy, done} !== {32'h0, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL t4_end: got %0d/%0d busy=%b done=%b want 0/0 0 1",
                  gain1, gain2, busy, done);
      end
      cyc();
      nvec++;
      if (done !== 1'b0) begin
         nerr++; $display("FAIL t4_done_once: got %b want 0", done);
      end
   endtask

   // Test 5: shadow write coincident with commit commits the old shadow
   task automatic test_same_cycle();
      wr(ADDR_STEP, 16'd0);
      wr(ADDR_SHADOW1, 16'd700);
      lb_addr = ADDR_SHADOW1; lb_data = 16'hFD44; lb_write = 1'b1; commit = 1'b1;
      cyc();
      lb_write = 1'b0; commit = 1'b0;
      cyc();
      nvec++;
      if ({gain1, done} !== {16'd700, 1'b1}) begin
         nerr++; $display("FAIL t5_old: got %0d done=%b want 700 1", gain1, done);
      end
      cyc();
      pulse_commit();
      cyc();
      nvec++;
      if ({gain1, done} !== {16'hFD44, 1'b1}) begin
         nerr++; $display("FAIL t5_new: got %0d done=%b want -700 1", gain1, done);
      end
   endtask

   // Test 6: reset mid-ramp restores everything, including shadows
   task automatic test_reset_mid_ramp();
      wr(ADDR_STEP, 16'd100);
      wr(ADDR_SHADOW1, 16'd1000);
      wr(ADDR_SHADOW2, 16'hFC18);
      pulse_commit();
      cyc(); cyc();
      nvec++;
      if (busy !== 1'b1) begin
         nerr++; $display("FAIL t6_busy: got %b want 1", busy);
      end
      rst = 1'b1;
      cyc();
      nvec++;
      if ({gain1, gain2, busy, done} !== 34'b0) begin
         nerr++;
         $display("FAIL t6_rst: got %0d/%0d busy=%b done=%b want 0/0 0 0",
                  gain1, gain2, busy, done);
      end
      rst = 1'b0;
      cyc();
      nvec++;
      if ({gain1, gain2, busy, done} !== 34'b0) begin
         nerr++;
         $display("FAIL t6_post: got %0d/%0d busy=%b done=%b want 0/0 0 0",
                  gain1, gain2, busy, done);
      end
      pulse_commit();
      cyc();
      nvec++;
      if ({gain1, gain2, busy, done} !== {32'h0, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL t6_recommit: got %0d/%0d busy=%b done=%b want 0/0 0 1",
                  gain1, gain2, busy, done);
      end
   endtask

`endif

   initial begin
      test_reset();
`ifdef PHSHIFT_GAIN_RAMP_SNAP_EN
      test_snap();
`else
      test_ramp_basic();
      test_rate_wrap();
      test_step_zero();
      test_retarget();
      test_same_cycle();
      test_reset_mid_ramp();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/phshift_gain_ramp.md
Name: phshift_gain_ramp

Overview:
Host-side controller for the f_sample/8-class phase shifter's gain pair (gain1, gain2 driving gain1 + gain2*z^-2).
- Accepts shadow target gains from the local bus.
- Commits both targets atomically on one strobe.
- Slews the live gains toward the targets at a programmable step size and rate, so a phase change never produces a glitch or a transient mismatched gain pair.
- Sits between the local-bus register decode and the phase-shifter gain inputs.

Parameters:
RATE_W, 8, width of the rate-divisor register and prescaler counter.
GAIN1_INIT, 16'sd0, reset value of live and target gain1.
GAIN2_INIT, 16'sd0, reset value of live and target gain2.

Ports:
clk  input  1  datapath clock, single domain.
rst  input  1  synchronous, active-high reset.
lb_addr  input  2  register select: 0=shadow gain1, 1=shadow gain2, 2=step, 3=rate.
lb_data  input  16  write data.
lb_write  input  1  write strobe, one cycle per write.
commit  input  1  one-cycle pulse: copy both shadows to active targets.
gain1  output  16 signed  live gain1 to the phase shifter.
gain2  output  16 signed  live gain2 to the phase shifter.
busy  output  1  high while in RAMP.
done  output  1  one-cycle pulse when both live gains equal their targets after a commit.

Behaviour:
- Registers:
  - shadow1 and shadow2 are 16-bit signed.
  - step is 15-bit unsigned, taken from lb_data[14:0].
  - rate is RATE_W-bit unsigned, taken from lb_data[RATE_W-1:0].
- Reset values:
  - shadow1, target1 and gain1 = GAIN1_INIT; shadow2, target2 and gain2 = GAIN2_INIT.
  - step=0, rate=0, prescaler=0, state IDLE, busy=0, done=0.
- A shadow write takes effect the next cycle and never changes the live gains.
- commit at cycle n:
  - target1/2 load from shadow1/2 at n+1. If lb_write hits a shadow on the same cycle, the old shadow value is committed.
  - The prescaler clears.
  - State goes to RAMP; busy=1 from n+1.
- Prescaler:
  - Counts 0..rate while in RAMP.
  - A tick fires on the cycle count==rate, then the counter returns to 0.
  - rate=0 gives a tick every cycle. The first tick arrives rate+1 cycles after commit.
- On each tick, per gain independently:
  - diff = target - gain, computed at 17 bits (no overflow).
  - If step==0 or |diff| <= step: gain <= target.
  - Otherwise gain <= gain + step (diff>0) or gain - step (diff<0), computed at 17 bits.
  - The result never overshoots the target and never wraps.
- Both gains update on the same clock edge.
- State machine (IDLE, RAMP):
  - IDLE to RAMP on commit.
  - RAMP to IDLE on the cycle after which both gains equal their targets; done=1 for exactly that one cycle and busy drops with it.
  - A commit whose targets equal the current gains still passes through RAMP and pulses done at the first tick.
- A commit while in RAMP:
  - Retargets immediately; the ramp continues from the present live gains with the prescaler cleared.
  - No done pulse for the abandoned target.
- step or rate writes during RAMP apply from the next tick.
- rst mid-ramp: all state returns to reset values on that edge; done is not pulsed.

Optional Feature:
PHSHIFT_GAIN_RAMP_SNAP_EN
- Defined: the step and rate registers and the prescaler are removed. On commit, gain1/2 load the shadows directly at n+1; busy stays 0; done pulses at n+1. Writes to addresses 2 and 3 are ignored.
- Undefined: full ramp behaviour as above.

Decomposition:
- Shared package holds:
  - register address constants (ADDR_SHADOW1=0, ADDR_SHADOW2=1, ADDR_STEP=2, ADDR_RATE=3);
  - the state encoding (IDLE, RAMP);
  - the 16-bit gain and 17-bit difference widths.
- One sub-module is natural: ramp_step, a combinational current/target/step to next-value slew limiter. It is instantiated twice, once per gain.

Test Plan:
1. Reset, then shadow1=1000, shadow2=-1000, step=100, rate=0, commit -> gains move ±100 per cycle; reach 1000/-1000 after 10 ticks; done pulses once; busy high for the 10 cycles before that.
2. rate=3, step=16384, shadow1=32767, shadow2=-32768 from 0, commit -> first change 4 cycles after commit; gain1 goes 16384 then 32767, gain2 goes -16384 then -32768, with no wrap; done on the second tick.
3. step=0, shadow1=-500, commit -> gain1 jumps to -500 at the first tick; done next.
4. Mid-ramp (gain1 at 300, heading to 1000), write shadow1=0 and commit -> gain1 ramps down from 300 to 0; single done only for the new target.
5. commit and lb_write to shadow1 on the same cycle -> the old shadow value is committed; the new value applies only on the next commit.
6. rst asserted mid-ramp -> next cycle gain1/2=GAIN1_INIT/GAIN2_INIT, busy=0, done=0; with SNAP_EN defined, rerun test 1 -> gains equal 1000/-1000 one cycle after commit.
